// File: rtl/vector_cache_pkg.sv
// Shared vector-cache types plus the read-return collector's slot states and sizing constants.
package vector_cache_pkg;

    localparam int unsigned TXNID_W             = 8;
    localparam int unsigned RD_COLLECT_LANES    = 8;
    localparam int unsigned RD_COLLECT_SLOT_NUM = 16;
    localparam int unsigned RD_COLLECT_BEATS    = 8;
    localparam int unsigned RD_COLLECT_BEAT_W   = $clog2(RD_COLLECT_BEATS);

    typedef struct packed {
        logic [TXNID_W-1:0]           txnid;
        logic [RD_COLLECT_BEAT_W-1:0] byte_sel;
    } sram_inst_cmd_t;

    typedef struct packed {
        sram_inst_cmd_t cmd_pld;
        logic [31:0]    data;
    } data_pld_t;

    typedef enum logic [1:0] {
        SlotIdle,
        SlotFill,
        SlotDone,
        SlotOut
    } rd_collect_slot_st_e;

endpackage

// File: rtl/vec_cache_rd_data_collect_if.sv
// Ring read-return lanes in, completed lines out, plus sticky protocol error flags.
interface vec_cache_rd_data_collect_if;
    import vector_cache_pkg::*;

    logic [RD_COLLECT_LANES-1:0]       data_in_vld;
    data_pld_t [RD_COLLECT_LANES-1:0]  data_in;
    logic                              rsp_vld;
    logic                              rsp_rdy;
    logic [TXNID_W-1:0]                rsp_txnid;
    logic [RD_COLLECT_BEATS*32-1:0]    rsp_data;
    logic                              err_dup;
    logic                              err_alias;
    logic                              err_overrun;

    modport master (
        output data_in_vld, data_in, rsp_rdy,
        input  rsp_vld, rsp_txnid, rsp_data, err_dup, err_alias, err_overrun
    );

    modport slave (
        input  data_in_vld, data_in, rsp_rdy,
        output rsp_vld, rsp_txnid, rsp_data, err_dup, err_alias, err_overrun
    );

endinterface

// File: rtl/vec_cache_rr_arb.sv
// Round-robin arbiter: searches from the pointer upward; pointer moves past the grant on adv.
module vec_cache_rr_arb #(
    parameter int unsigned N = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 adv,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);
    localparam int unsigned IDX_W = $clog2(N);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            int unsigned k;
            k = (32'(ptr_q) + i) % N;
            if (!found && req[k]) begin
                found   = 1'b1;
                gnt[k]  = 1'b1;
                gnt_idx = IDX_W'(k);
            end
        end
        ptr_d = ptr_q;
        if (adv && found) begin
            ptr_d = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/vec_cache_rd_data_collect.sv
// Reassembles ring read-return beats into full lines per txnid slot and hands them out
// one per cycle over valid/ready; the ring cannot stall, so violations only raise flags.
module vec_cache_rd_data_collect
    import vector_cache_pkg::*;
#(
    parameter int unsigned LANES    = RD_COLLECT_LANES,
    parameter int unsigned SLOT_NUM = RD_COLLECT_SLOT_NUM,
    parameter int unsigned BEATS    = RD_COLLECT_BEATS
) (
    input logic                        clk,
    input logic                        rst_n,
    vec_cache_rd_data_collect_if.slave bus
);
    localparam int unsigned SLOT_W = $clog2(SLOT_NUM);
    localparam int unsigned BEAT_W = $clog2(BEATS);

    typedef logic [BEATS-1:0][31:0] line_t;

    rd_collect_slot_st_e [SLOT_NUM-1:0]   st_q, st_d;
    logic [SLOT_NUM-1:0][BEATS-1:0]       mask_q, mask_d;
    logic [SLOT_NUM-1:0][TXNID_W-1:0]     txnid_q, txnid_d;
    line_t [SLOT_NUM-1:0]                 data_q, data_d;
    logic [SLOT_W-1:0]                    out_slot_q, out_slot_d;
    logic                                 rsp_vld_q, rsp_vld_d;
    logic [TXNID_W-1:0]                   rsp_txnid_q, rsp_txnid_d;
    line_t                                rsp_data_q, rsp_data_d;
    logic                                 err_dup_q, err_dup_d;
    logic                                 err_alias_q, err_alias_d;
    logic                                 err_overrun_q, err_overrun_d;

    logic [SLOT_NUM-1:0] done_req, gnt;
    logic [SLOT_W-1:0]   gnt_idx;
    logic                load_en, rsp_fire;

    assign load_en  = !rsp_vld_q || bus.rsp_rdy;
    assign rsp_fire = rsp_vld_q && bus.rsp_rdy;

    always_comb begin
        for (int s = 0; s < SLOT_NUM; s++) done_req[s] = (st_q[s] == SlotDone);
    end

    vec_cache_rr_arb #(.N(SLOT_NUM)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (done_req),
        .adv     (load_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        logic [SLOT_W-1:0]  slot;
        logic [BEAT_W-1:0]  beat;
        logic [TXNID_W-1:0] txn;
        slot          = '0;
        beat          = '0;
        txn           = '0;
        st_d          = st_q;
        mask_d        = mask_q;
        txnid_d       = txnid_q;
        data_d        = data_q;
        out_slot_d    = out_slot_q;
        rsp_vld_d     = rsp_vld_q;
        rsp_txnid_d   = rsp_txnid_q;
        rsp_data_d    = rsp_data_q;
        err_dup_d     = err_dup_q;
        err_alias_d   = err_alias_q;
        err_overrun_d = err_overrun_q;

        // Release happens first so a beat landing on the freed slot opens a fresh fill.
        if (rsp_fire) begin
            st_d[out_slot_q]    = SlotIdle;
            mask_d[out_slot_q]  = '0;
            txnid_d[out_slot_q] = '0;
        end

        if (load_en) begin
            rsp_vld_d = |done_req;
            if (|done_req) begin
                for (int s = 0; s < SLOT_NUM; s++) if (gnt[s]) st_d[s] = SlotOut;
                out_slot_d  = gnt_idx;
                rsp_txnid_d = txnid_q[gnt_idx];
                rsp_data_d  = data_q[gnt_idx];
            end
        end

        // Ascending lane order lets the higher lane win when two lanes hit the same beat.
        for (int l = 0; l < LANES; l++) begin
            if (bus.data_in_vld[l]) begin
                txn  = bus.data_in[l].cmd_pld.txnid;
                slot = txn[SLOT_W-1:0];
                beat = bus.data_in[l].cmd_pld.byte_sel[BEAT_W-1:0];
                case (st_d[slot])
                    SlotIdle: begin
                        st_d[slot]         = SlotFill;
                        txnid_d[slot]      = txn;
                        mask_d[slot][beat] = 1'b1;
                        data_d[slot][beat] = bus.data_in[l].data;
                    end
                    SlotFill: begin
                        if (txnid_d[slot] != txn) begin
                            err_alias_d = 1'b1;
                        end else begin
                            if (mask_d[slot][beat]) err_dup_d = 1'b1;
                            mask_d[slot][beat] = 1'b1;
                            data_d[slot][beat] = bus.data_in[l].data;
                        end
                    end
                    default: err_overrun_d = 1'b1;
                endcase
            end
        end

        for (int s = 0; s < SLOT_NUM; s++) begin
            if (st_d[s] == SlotFill && &mask_d[s]) st_d[s] = SlotDone;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SLOT_NUM; s++) st_q[s] <= SlotIdle;
            mask_q        <= '0;
            txnid_q       <= '0;
            data_q        <= '0;
            out_slot_q    <= '0;
            rsp_vld_q     <= 1'b0;
            rsp_txnid_q   <= '0;
            rsp_data_q    <= '0;
            err_dup_q     <= 1'b0;
            err_alias_q   <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            st_q          <= st_d;
            mask_q        <= mask_d;
            txnid_q       <= txnid_d;
            data_q        <= data_d;
            out_slot_q    <= out_slot_d;
            rsp_vld_q     <= rsp_vld_d;
            rsp_txnid_q   <= rsp_txnid_d;
            rsp_data_q    <= rsp_data_d;
            err_dup_q     <= err_dup_d;
            err_alias_q   <= err_alias_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    assign bus.rsp_vld     = rsp_vld_q;
    assign bus.rsp_txnid   = rsp_txnid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.err_dup     = err_dup_q;
    assign bus.err_alias   = err_alias_q;
    assign bus.err_overrun = err_overrun_q;

endmodule

// File: tb/tb_vec_cache_rd_data_collect.sv
// Directed bench: a per-slot line model with a pending-line set feeds a per-cycle checker.
module tb_vec_cache_rd_data_collect;
    import vector_cache_pkg::*;

    localparam int NS = RD_COLLECT_SLOT_NUM;
    localparam int NB = RD_COLLECT_BEATS;
    localparam int NL = RD_COLLECT_LANES;
    localparam int W  = NB * 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    vec_cache_rd_data_collect_if bus ();

    vec_cache_rd_data_collect dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: slot is idle, filling, or busy (complete and not yet handed over).
    typedef enum int {MIdle, MFill, MBusy} mst_e;
    mst_e               m_st       [NS];
    logic [TXNID_W-1:0] m_txn      [NS];
    logic [NB-1:0]      m_mask     [NS];
    logic [31:0]        m_word     [NS][NB];
    bit                 m_pend     [NS];
    logic [TXNID_W-1:0] m_pend_txn [NS];
    logic [W-1:0]       m_pend_line[NS];
    int                 m_ptr;
    bit                 m_dup, m_alias, m_over;

    function automatic int pick();
        for (int i = 0; i < NS; i++) begin
            int k;
            k = (m_ptr + i) % NS;
            if (m_pend[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            m_st[s] = MIdle; m_txn[s] = '0; m_mask[s] = '0; m_pend[s] = 1'b0;
        end
        m_ptr = 0; m_dup = 1'b0; m_alias = 1'b0; m_over = 1'b0;
    endtask

    task automatic model_edge(input bit hs);
        if (hs) begin
            int k;
            k = pick();
            if (k >= 0) begin
                m_pend[k] = 1'b0; m_st[k] = MIdle; m_mask[k] = '0; m_ptr = (k + 1) % NS;
            end
        end
        for (int l = 0; l < NL; l++) begin
            if (bus.data_in_vld[l]) begin
                logic [TXNID_W-1:0] t;
                int s, b;
                t = bus.data_in[l].cmd_pld.txnid;
                s = int'(t) % NS;
                b = int'(bus.data_in[l].cmd_pld.byte_sel) % NB;
                if (m_st[s] == MIdle) begin
                    m_st[s] = MFill; m_txn[s] = t; m_mask[s][b] = 1'b1;
                    m_word[s][b] = bus.data_in[l].data;
                end else if (m_st[s] == MFill) begin
                    if (t != m_txn[s]) m_alias = 1'b1;
                    else begin
                        if (m_mask[s][b]) m_dup = 1'b1;
                        m_mask[s][b] = 1'b1;
                        m_word[s][b] = bus.data_in[l].data;
                    end
                end else begin
                    m_over = 1'b1;
                end
            end
        end
        for (int s = 0; s < NS; s++) begin
            if (m_st[s] == MFill && &m_mask[s]) begin
                m_st[s] = MBusy; m_pend[s] = 1'b1; m_pend_txn[s] = m_txn[s];
                for (int b = 0; b < NB; b++) m_pend_line[s][b*32 +: 32] = m_word[s][b];
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_edge(bus.rsp_vld && bus.rsp_rdy);
        end
    end

    // Per-cycle compare against the model.
    initial begin
        logic pv, pr;
        logic [TXNID_W-1:0] pt;
        logic [W-1:0] pd;
        int k;
        pv = 1'b0; pr = 1'b0; pt = '0; pd = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("err_dup", W'(bus.err_dup), W'(m_dup));
                chk("err_alias", W'(bus.err_alias), W'(m_alias));
                chk("err_overrun", W'(bus.err_overrun), W'(m_over));
                if (pv && !pr) begin
                    chk("hold rsp_vld", W'(bus.rsp_vld), W'(1));
                    chk("hold rsp_txnid", W'(bus.rsp_txnid), W'(pt));
                    chk("hold rsp_data", bus.rsp_data, pd);
                end
                if (bus.rsp_vld) begin
                    k = pick();
                    if (k < 0) chk("spurious rsp_vld", W'(bus.rsp_vld), W'(0));
                    else if (bus.rsp_rdy) begin
                        chk("rsp_txnid", W'(bus.rsp_txnid), W'(m_pend_txn[k]));
                        chk("rsp_data", bus.rsp_data, m_pend_line[k]);
                    end
                end
                pv = bus.rsp_vld; pr = bus.rsp_rdy; pt = bus.rsp_txnid; pd = bus.rsp_data;
            end else begin
                pv = 1'b0;
            end
        end
    end

    task automatic beat(input int lane, input logic [TXNID_W-1:0] txn, input int b,
                        input logic [31:0] w);
        bus.data_in_vld[lane]               = 1'b1;
        bus.data_in[lane].cmd_pld.txnid     = txn;
        bus.data_in[lane].cmd_pld.byte_sel  = b[RD_COLLECT_BEAT_W-1:0];
        bus.data_in[lane].data              = w;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.data_in_vld = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        bus.data_in_vld = '0;
        bus.data_in     = '0;
        bus.rsp_rdy     = 1'b1;
        repeat (2) @(posedge clk);
        chk("reset rsp_vld", W'(bus.rsp_vld), W'(0));
        chk("reset rsp_txnid", W'(bus.rsp_txnid), W'(0));
        chk("reset rsp_data", bus.rsp_data, W'(0));
        chk("reset errs", W'({bus.err_dup, bus.err_alias, bus.err_overrun}), W'(0));
        #1 rst_n = 1'b1;
        idle(1);

        // Single-cycle line, txnid 0x05.
        for (int b = 0; b < 8; b++) beat(b, 8'h05, b, 32'(32'h100 + b));
        tick();
        @(negedge clk);
        chk("t1 vld after E", W'(bus.rsp_vld), W'(0));
        tick();
        chk("t1 vld after E+1", W'(bus.rsp_vld), W'(1));
        chk("t1 txnid", W'(bus.rsp_txnid), W'(8'h05));
        chk("t1 word3", W'(bus.rsp_data[3*32 +: 32]), W'(32'h103));
        idle(3);

        // Spread fill, txnid 0x03, beats 7..0 on lane 2.
        for (int b = 7; b >= 0; b--) begin
            beat(2, 8'h03, b, 32'(32'h300 + b));
            tick();
        end
        @(negedge clk);
        chk("t2 vld after E", W'(bus.rsp_vld), W'(0));
        tick();
        chk("t2 vld after E+1", W'(bus.rsp_vld), W'(1));
        chk("t2 word7", W'(bus.rsp_data[7*32 +: 32]), W'(32'h307));
        idle(3);

        // Backpressure and round-robin over slots 1, 2, 3 completing together.
        bus.rsp_rdy = 1'b0;
        for (int s = 1; s <= 3; s++) begin
            for (int b = 0; b < 7; b++) beat(b, 8'(s), b, 32'(32'h1000 * s + b));
            tick();
        end
        for (int s = 1; s <= 3; s++) beat(s - 1, 8'(s), 7, 32'(32'h1000 * s + 7));
        tick();
        idle(1);
        for (int i = 0; i < 5; i++) begin
            chk("t3 stall txnid", W'(bus.rsp_txnid), W'(8'h01));
            if (i < 4) tick();
        end
        bus.rsp_rdy = 1'b1;
        tick();
        chk("t3 second txnid", W'(bus.rsp_txnid), W'(8'h02));
        tick();
        chk("t3 third txnid", W'(bus.rsp_txnid), W'(8'h03));
        tick();
        chk("t3 drained", W'(bus.rsp_vld), W'(0));
        idle(2);

        // Duplicate (cross-cycle and same-cycle), alias, overrun on slot 4.
        for (int b = 0; b < 3; b++) beat(b, 8'h04, b, 32'(32'h400 + b));
        tick();
        beat(1, 8'h04, 2, 32'h4A2);
        beat(5, 8'h04, 2, 32'h4B2);
        tick();
        chk("t4 err_dup", W'(bus.err_dup), W'(1));
        beat(0, 8'h14, 3, 32'hBAD);
        tick();
        chk("t4 err_alias", W'(bus.err_alias), W'(1));
        for (int b = 3; b < 8; b++) beat(b, 8'h04, b, 32'(32'h400 + b));
        tick();
        beat(0, 8'h04, 0, 32'hDEAD);
        tick();
        chk("t4 err_overrun", W'(bus.err_overrun), W'(1));
        chk("t4 txnid", W'(bus.rsp_txnid), W'(8'h04));
        chk("t4 word0", W'(bus.rsp_data[0 +: 32]), W'(32'h400));
        chk("t4 word2", W'(bus.rsp_data[2*32 +: 32]), W'(32'h4B2));
        chk("t4 word3", W'(bus.rsp_data[3*32 +: 32]), W'(32'h403));
        idle(3);

        // Reset mid-fill of txnid 0x07, then a fresh full line.
        for (int b = 0; b < 4; b++) beat(b, 8'h07, b, 32'(32'h700 + b));
        tick();
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("t6 rst rsp_vld", W'(bus.rsp_vld), W'(0));
        chk("t6 rst rsp_txnid", W'(bus.rsp_txnid), W'(0));
        chk("t6 rst rsp_data", bus.rsp_data, W'(0));
        chk("t6 rst errs", W'({bus.err_dup, bus.err_alias, bus.err_overrun}), W'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int b = 0; b < 8; b++) beat(b, 8'h07, b, 32'(32'h780 + b));
        tick();
        idle(1);
        chk("t6 vld", W'(bus.rsp_vld), W'(1));
        chk("t6 txnid", W'(bus.rsp_txnid), W'(8'h07));
        chk("t6 word0", W'(bus.rsp_data[0 +: 32]), W'(32'h780));
        chk("t6 word4", W'(bus.rsp_data[4*32 +: 32]), W'(32'h784));
        idle(3);

        // First beat of a new txnid on the same edge its slot is released.
        for (int b = 0; b < 8; b++) beat(b, 8'h09, b, 32'(32'h900 + b));
        tick();
        idle(1);
        beat(0, 8'h19, 0, 32'h1900);
        tick();
        chk("t7 no overrun", W'(bus.err_overrun), W'(0));
        for (int b = 1; b < 8; b++) beat(b, 8'h19, b, 32'(32'h1900 + b));
        tick();
        idle(1);
        chk("t7 vld", W'(bus.rsp_vld), W'(1));
        chk("t7 txnid", W'(bus.rsp_txnid), W'(8'h19));
        chk("t7 word0", W'(bus.rsp_data[0 +: 32]), W'(32'h1900));

        for (int i = 0; i < 20; i++) begin
            if (!bus.rsp_vld) break;
            tick();
        end
        chk("final drain", W'(bus.rsp_vld), W'(0));
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
